// File: rtl/adc_spi_pkg.sv
// Shared constants, state type and command-bit helper for the MCP3202-style ADC reader.
package adc_spi_pkg;

  localparam int ADC_W           = 12;
  localparam int FRAME_BITS      = 17;
  localparam int CMD_BITS        = 4;
  localparam int DATA_FIRST_RISE = 6;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } adc_state_t;

  // Din value presented for a given rising-edge number (1-based); zero after the command.
  function automatic logic cmd_bit(input logic [4:0] rise, input logic ch);
    logic b;
    b = 1'b0;
    if (rise <= 5'(CMD_BITS)) begin
      case (rise)
        5'd1:    b = CMD_START;
        5'd2:    b = CMD_SGL;
        5'd3:    b = ch;
        5'd4:    b = CMD_MSBF;
        default: b = 1'b0;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// SPI pin bundle between the reader (master) and the ADC (slave).
interface adc_spi_reader_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/adc_spi_reader_sclk_tick_gen.sv
// SCLK generator: CLK_DIV clk cycles per half period, low first, idle low while run=0.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV);

  if (CLK_DIV < 2) begin : g_div_chk
    $error("sclk_tick_gen: CLK_DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  always_comb begin
    half_end  = run && (cnt_q == CW'(CLK_DIV - 1));
    rise_tick = half_end && !sclk_q;
    fall_tick = half_end && sclk_q;
    cnt_d     = cnt_q + CW'(1);
    sclk_d    = sclk_q;
    if (!run) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_end) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for a 2-channel 12-bit ADC, converting ch0/ch1 alternately.
// Optional build macro ADC_AVG_EN: publish the 4-sample moving average per channel.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  adc_spi_reader_if.master        spi,
  output logic [ADC_W-1:0]        p1data,
  output logic [ADC_W-1:0]        p2data,
  output logic                    p1_valid,
  output logic                    p2_valid,
  output logic                    busy
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (GAP_CYC < 1) begin : g_gap_chk
    $error("adc_spi_reader: GAP_CYC must be >= 1");
  end

  adc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [ADC_W-1:0] sh_q, sh_d;
  logic             ch_q, ch_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic [ADC_W-1:0] p1data_q, p1data_d, p2data_q, p2data_d;
  logic             p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic [ADC_W-1:0] result, pub;
  logic             sclk_w, rise_tick, fall_tick;

`ifdef ADC_AVG_EN
  logic [ADC_W-1:0] hist_q [2][4];
  logic [ADC_W-1:0] hist_d [2][4];
  logic [ADC_W+1:0] sum_q  [2];
  logic [ADC_W+1:0] sum_d  [2];

  function automatic logic [ADC_W-1:0] avg4(input logic [ADC_W+1:0] s);
    return s[ADC_W+1:2];
  endfunction
`endif

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (state_q == SHIFT),
    .sclk      (sclk_w),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    ch_d       = ch_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    p1data_d   = p1data_q;
    p2data_d   = p2data_q;
    p1_valid_d = 1'b0;
    p2_valid_d = 1'b0;
    result     = {sh_q[ADC_W-2:0], spi.miso};
    pub        = result;
`ifdef ADC_AVG_EN
    hist_d = hist_q;
    sum_d  = sum_q;
`endif
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        if (enable) begin
          state_d = CS_SETUP;
          cyc_d   = '0;
          cs_n_d  = 1'b0;
          mosi_d  = CMD_START;
        end
      end
      CS_SETUP: begin
        if (cyc_q == CNT_W'(CLK_DIV - 1)) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // Rises before DATA_FIRST_RISE carry command echo / null bit and are not kept.
        if (rise_tick) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q + 5'd1 >= 5'(DATA_FIRST_RISE)) sh_d = result;
          if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
`ifdef ADC_AVG_EN
            sum_d[ch_q]     = sum_q[ch_q] - (ADC_W+2)'(hist_q[ch_q][3]) + (ADC_W+2)'(result);
            hist_d[ch_q][0] = result;
            hist_d[ch_q][1] = hist_q[ch_q][0];
            hist_d[ch_q][2] = hist_q[ch_q][1];
            hist_d[ch_q][3] = hist_q[ch_q][2];
            pub             = avg4(sum_d[ch_q]);
`endif
            if (ch_q) begin
              p2data_d   = pub;
              p2_valid_d = 1'b1;
            end else begin
              p1data_d   = pub;
              p1_valid_d = 1'b1;
            end
          end
        end
        if (fall_tick) begin
          mosi_d = cmd_bit(bit_cnt_q + 5'd1, ch_q);
          if (bit_cnt_q == 5'(FRAME_BITS)) begin
            state_d = CS_HOLD;
            cyc_d   = '0;
          end
        end
      end
      CS_HOLD: begin
        if (cyc_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = GAP;
          cyc_d   = '0;
          cs_n_d  = 1'b1;
          ch_d    = !ch_q;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cyc_q == CNT_W'(GAP_CYC - 1)) begin
          cyc_d = '0;
          if (enable) begin
            state_d = CS_SETUP;
            cs_n_d  = 1'b0;
            mosi_d  = CMD_START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      ch_q       <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      p1data_q   <= '0;
      p2data_q   <= '0;
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ch_q       <= ch_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      p1data_q   <= p1data_d;
      p2data_q   <= p2data_d;
      p1_valid_q <= p1_valid_d;
      p2_valid_q <= p2_valid_d;
    end
  end

`ifdef ADC_AVG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        sum_q[c] <= '0;
        for (int k = 0; k < 4; k++) hist_q[c][k] <= '0;
      end
    end else begin
      sum_q  <= sum_d;
      hist_q <= hist_d;
    end
  end
`endif

  assign spi.sclk = sclk_w;
  assign spi.cs_n = cs_n_q;
  assign spi.mosi = mosi_q;
  assign p1data   = p1data_q;
  assign p2data   = p2data_q;
  assign p1_valid = p1_valid_q;
  assign p2_valid = p2_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: behavioural ADC on the SPI pins, vector table plus corner sequences.
module tb_adc_spi_reader;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 16;
  localparam int PERIOD  = CLK_DIV * 36 + GAP_CYC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] p1data, p2data;
  logic        p1_valid, p2_valid, busy;

  adc_spi_reader_if spi ();

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .spi      (spi),
    .p1data   (p1data),
    .p2data   (p2data),
    .p1_valid (p1_valid),
    .p2_valid (p2_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model and pin-timing monitor, evaluated away from the active edge.
  logic [11:0] adc_ch0 = '0, adc_ch1 = '0;
  logic        sclk_prev = 1'b0, csn_prev = 1'b1, mosi_prev = 1'b0;
  logic        p1v_prev = 1'b0, p2v_prev = 1'b0;
  logic        mon_ch = 1'b0;
  logic [3:0]  cmd_sh = '0, mon_cmd = '0;
  int          mon_rise = 0, lvl_cnt = 0, hi_cnt = 0, nxt = 0;
  int          terr = 0, tchk = 0;
  bit          skip_gap = 1'b1;
  logic [11:0] cur;

  initial spi.miso = 1'b0;

  always @(negedge clk) begin
    if (p1_valid && p1v_prev) terr++;
    if (p2_valid && p2v_prev) terr++;
    if (reset) begin
      mon_rise = 0;
      lvl_cnt  = 0;
      skip_gap = 1'b1;
      spi.miso = 1'b0;
    end else if (spi.cs_n && !csn_prev) begin
      if (mon_rise == 17) begin
        tchk++;
        if (lvl_cnt != CLK_DIV) terr++;
      end
      hi_cnt = 1;
    end else if (!spi.cs_n && csn_prev) begin
      if (!skip_gap) begin
        tchk++;
        if (hi_cnt < GAP_CYC) terr++;
      end
      skip_gap = 1'b0;
      mon_rise = 0;
      lvl_cnt  = 1;
      cmd_sh   = '0;
      tchk++;
      if (spi.mosi !== 1'b1) terr++;
    end else if (spi.cs_n) begin
      hi_cnt++;
    end else if (spi.sclk && !sclk_prev) begin
      mon_rise++;
      tchk++;
      if (lvl_cnt != ((mon_rise == 1) ? 2 * CLK_DIV : CLK_DIV)) terr++;
      if (spi.mosi !== mosi_prev) terr++;
      if (mon_rise <= 4) cmd_sh = {cmd_sh[2:0], spi.mosi};
      if (mon_rise == 3) mon_ch = spi.mosi;
      if (mon_rise == 4) mon_cmd = cmd_sh;
      lvl_cnt = 1;
    end else if (!spi.sclk && sclk_prev) begin
      tchk++;
      if (lvl_cnt != CLK_DIV) terr++;
      nxt = mon_rise + 1;
      cur = mon_ch ? adc_ch1 : adc_ch0;
      spi.miso = (nxt >= 6 && nxt <= 17) ? cur[17 - nxt] : 1'b0;
      lvl_cnt = 1;
    end else begin
      lvl_cnt++;
    end
    sclk_prev = spi.sclk;
    csn_prev  = spi.cs_n;
    mosi_prev = spi.mosi;
    p1v_prev  = p1_valid;
    p2v_prev  = p2_valid;
  end

  // Wait for the next valid strobe; which=0 means the budget ran out.
  task automatic wait_valid(input int budget, output int which, output logic [11:0] d, output int waited);
    which  = 0;
    d      = '0;
    waited = 0;
    while (which == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
      if (p1_valid) begin
        which = 1;
        d     = p1data;
      end else if (p2_valid) begin
        which = 2;
        d     = p2data;
      end
    end
  endtask

  task automatic wait_rise(input int rise_no, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!spi.cs_n && mon_rise == rise_no && mon_ch == 1'b0) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [11:0] ch0;
    logic [11:0] ch1;
    logic [11:0] exp1;
    logic [11:0] exp2;
  } vec_t;

  vec_t        vt [5];
  int          which, waited, nvec;
  logic [11:0] d;
  bit          ok, saw_valid;

  initial begin
`ifdef ADC_AVG_EN
    vt[0] = '{12'h400, 12'h000, 12'h100, 12'h000};
    vt[1] = '{12'h400, 12'h000, 12'h200, 12'h000};
    vt[2] = '{12'h400, 12'h000, 12'h300, 12'h000};
    vt[3] = '{12'h400, 12'h000, 12'h400, 12'h000};
    vt[4] = '{12'h800, 12'h000, 12'h500, 12'h000};
    nvec  = 5;
`else
    vt[0] = '{12'hABC, 12'h123, 12'hABC, 12'h123};
    vt[1] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    vt[2] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
    vt[3] = '{12'h5A5, 12'hA5A, 12'h5A5, 12'hA5A};
    vt[4] = '{12'h801, 12'h7FE, 12'h801, 12'h7FE};
    nvec  = 5;
`endif

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(spi.cs_n), 32'd1);
    chk("rst_sclk", 32'(spi.sclk), 32'd0);
    chk("rst_mosi", 32'(spi.mosi), 32'd0);
    chk("rst_p1data", 32'(p1data), 32'd0);
    chk("rst_p2data", 32'(p2data), 32'd0);
    chk("rst_valids", 32'({p1_valid, p2_valid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    adc_ch0 = vt[0].ch0;
    adc_ch1 = vt[0].ch1;
    reset   = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < nvec; i++) begin
      adc_ch0 = vt[i].ch0;
      adc_ch1 = vt[i].ch1;
      wait_valid(3 * PERIOD, which, d, waited);
      chk($sformatf("v%0d_p1_strobe", i), 32'(which), 32'd1);
      chk($sformatf("v%0d_p1data", i), 32'(d), 32'(vt[i].exp1));
      chk($sformatf("v%0d_cmd_ch0", i), 32'(mon_cmd), 32'b1101);
      if (i > 0) chk($sformatf("v%0d_period_p2p1", i), 32'(waited), 32'(PERIOD));
      wait_valid(3 * PERIOD, which, d, waited);
      chk($sformatf("v%0d_p2_strobe", i), 32'(which), 32'd2);
      chk($sformatf("v%0d_p2data", i), 32'(d), 32'(vt[i].exp2));
      chk($sformatf("v%0d_cmd_ch1", i), 32'(mon_cmd), 32'b1111);
      chk($sformatf("v%0d_period_p1p2", i), 32'(waited), 32'(PERIOD));
      chk($sformatf("v%0d_p1_kept", i), 32'(p1data), 32'(vt[i].exp1));
    end

`ifndef ADC_AVG_EN
    // enable dropped mid ch0 frame: frame finishes, then idle; resumes on ch1
    adc_ch0 = 12'h3C3;
    wait_rise(10, 3 * PERIOD, ok);
    chk("drop_reach_rise10", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_valid(2 * PERIOD, which, d, waited);
    chk("drop_p1_strobe", 32'(which), 32'd1);
    chk("drop_p1data", 32'(d), 32'h3C3);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (p1_valid || p2_valid) saw_valid = 1'b1;
    end
    chk("drop_no_more_valid", 32'(saw_valid), 32'd0);
    chk("drop_idle_cs_n", 32'(spi.cs_n), 32'd1);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    adc_ch1 = 12'h456;
    enable  = 1'b1;
    wait_valid(2 * PERIOD, which, d, waited);
    chk("resume_p2_strobe", 32'(which), 32'd2);
    chk("resume_p2data", 32'(d), 32'h456);
    chk("resume_cmd_ch1", 32'(mon_cmd), 32'b1111);
    chk("resume_p1_kept", 32'(p1data), 32'h3C3);

    // reset mid frame discards the partial conversion
    adc_ch0 = 12'h777;
    wait_rise(8, 3 * PERIOD, ok);
    chk("rst_reach_rise8", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(spi.cs_n), 32'd1);
    chk("abort_sclk", 32'(spi.sclk), 32'd0);
    chk("abort_mosi", 32'(spi.mosi), 32'd0);
    chk("abort_p1data", 32'(p1data), 32'd0);
    chk("abort_p2data", 32'(p2data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (p1_valid || p2_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(saw_valid), 32'd0);
    adc_ch0 = 12'h0F0;
    reset   = 1'b0;
    wait_valid(2 * PERIOD, which, d, waited);
    chk("restart_p1_strobe", 32'(which), 32'd1);
    chk("restart_p1data", 32'(d), 32'h0F0);
    chk("restart_cmd_ch0", 32'(mon_cmd), 32'b1101);
    chk("restart_p2_zero", 32'(p2data), 32'd0);
`endif

    chk("pin_timing_violations", 32'(terr), 32'd0);
    chk("pin_timing_observed", 32'(tchk > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
